instr_fetch_ctrl: RTL and testbench
===================================

Name: instr_fetch_ctrl

Overview:
Instruction-fetch requester for the multicycle RISC-V core and the initiator side of the instr_rom read port. It holds the PC, drives the ROM word address, and waits out the ROM's registered read latency. It then captures the instruction word and hands it to the core control FSM with a one-cycle valid pulse. It also handles PC increment and redirect, flush of an in-flight fetch, and misaligned-PC faults.

Parameters:
ADDR_W, 14, width of ROM byte address driven to the ROM (i_addr[13:0] on the ROM side)
RESET_PC, 32'h00000000, PC value after reset
ROM_LATENCY, 1, number of clock edges between a stable ROM address and valid ROM data (range 1..3)

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
i_fetch_req  in  1  control FSM requests a fetch at current/effective PC
i_pc_inc  in  1  PC <= PC + 4 (accepted only in IDLE)
i_pc_load  in  1  PC <= i_pc_next (accepted only in IDLE; priority over i_pc_inc)
i_pc_next  in  32  redirect target (branch/jump)
i_flush  in  1  abort in-flight fetch
o_rom_addr  out  ADDR_W  byte address to ROM, = pc_q[ADDR_W-1:0]
i_rom_data  in  32  registered ROM read data
o_instr  out  32  captured instruction word
o_fetch_pc  out  32  PC the captured instruction/fault belongs to
o_instr_valid  out  1  one-cycle pulse: o_instr/o_fetch_pc valid
o_fault  out  1  one-cycle pulse: misaligned fetch PC
o_busy  out  1  high in WAIT and CAPT
o_pc  out  32  current pc_q

Behaviour:
- Async reset (rst_n low): state=IDLE, pc_q=RESET_PC, lat_cnt=0, o_instr=0, o_fetch_pc=0, o_instr_valid=0, o_fault=0. o_busy=0 and o_rom_addr=RESET_PC[ADDR_W-1:0] follow from state and pc_q. Reset mid-fetch discards the fetch, with no valid pulse.
- The following are computed in IDLE only:
  - Effective PC: pc_eff = i_pc_load ? i_pc_next : i_pc_inc ? pc_q+4 : pc_q. Addition wraps mod 2^32.
  - pc_q <= pc_eff at each IDLE edge.
  - In WAIT/CAPT, i_pc_inc, i_pc_load and i_fetch_req are ignored and pc_q is held stable.
- FSM states: IDLE, WAIT, CAPT.
  - IDLE, i_fetch_req=1, pc_eff[1:0]!=0: stay IDLE; next cycle o_fault=1, o_fetch_pc=pc_eff; o_instr unchanged.
  - IDLE, i_fetch_req=1, aligned: go to WAIT, lat_cnt<=ROM_LATENCY. The fetch uses pc_eff, so a same-cycle load/inc plus request fetches the new PC.
  - WAIT: lat_cnt decrements each edge; when lat_cnt==1 at an edge, go to CAPT.
  - CAPT: at the edge, o_instr<=i_rom_data, o_fetch_pc<=pc_q, o_instr_valid<=1 for exactly the following cycle; go to IDLE.
  - Latency: request sampled at edge E0 gives o_instr_valid high in the cycle after edge E(ROM_LATENCY+1). With ROM_LATENCY=1 this is 2 cycles.
- i_flush in WAIT or CAPT: go to IDLE at that edge; no valid/fault pulse; o_instr retains its old value; pc_q unchanged. i_flush in IDLE has no effect, and a same-cycle i_fetch_req is dropped.
- o_instr_valid and o_fault are never high together, and each is high for one cycle only.
- Back-to-back: a request in the IDLE cycle that coincides with the valid pulse is accepted normally, giving a sustained rate of one fetch per ROM_LATENCY+2 cycles.
- ROM out-of-range (index >= ROM size) returns 0. It is passed through as instruction 0x00000000 and is not flagged here.

Test Plan:
- Reset, then i_fetch_req at PC 0 -> o_rom_addr=0x0000, o_instr_valid pulse 2 cycles later, o_instr=0x00000093, o_fetch_pc=0.
- i_pc_load=1, i_pc_next=0x14 with i_fetch_req in the same cycle -> fetches 0x14, o_instr=0x4ddf1663, o_fetch_pc=0x14; o_pc=0x14.
- Five consecutive fetches, each i_pc_inc+i_fetch_req, from 0x14 -> o_instr sequence 0x00100093, 0x00100113, 0x00208f33, 0x00200e93, 0x00300193; o_pc ends at 0x28.
- Redirect to 0x00000006 plus request -> o_fault pulse, o_fetch_pc=0x6, no o_instr_valid, o_instr unchanged.
- Request at 0x4f0, then assert i_flush in WAIT -> no valid pulse, o_busy low next cycle; re-request -> o_instr=0xc0001073.
- Fetch at 0x504 (beyond ROM) -> o_instr=0x00000000 valid. Then rst_n low during WAIT -> all outputs return to reset values immediately and no pulse follows.

Source files
------------

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_fetch_ctrl                                              |
// | Brief    : PC holder and instruction-fetch requester for the ROM port;   |
// |            waits out ROM read latency and pulses the captured word.      |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module instr_fetch_ctrl #(
   parameter int          ADDR_W      = 14,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          ROM_LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_fetch_req,
   input  logic              i_pc_inc,
   input  logic              i_pc_load,
   input  logic [31:0]       i_pc_next,
   input  logic              i_flush,
   output logic [ADDR_W-1:0] o_rom_addr,
   input  logic [31:0]       i_rom_data,
   output logic [31:0]       o_instr,
   output logic [31:0]       o_fetch_pc,
   output logic              o_instr_valid,
   output logic              o_fault,
   output logic              o_busy,
   output logic [31:0]       o_pc
);

   localparam logic [1:0] c_LAT_INIT = 2'(ROM_LATENCY);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_CAPT = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [31:0] r_pc;
   logic [1:0]  r_lat_cnt;
   logic [31:0] r_instr;
   logic [31:0] r_fetch_pc;
   logic        r_instr_valid;
   logic        r_fault;

   logic [31:0] w_pc_eff;
   logic        w_accept;
   logic        w_fault_evt;
   logic        w_capture;

   // Load wins over increment; the fetch is issued from this same-cycle value.
   assign w_pc_eff = i_pc_load ? i_pc_next :
                     i_pc_inc  ? r_pc + 32'd4 : r_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_fault_evt = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_fetch_req && !i_flush) begin
               if (w_pc_eff[1:0] != 2'b00) begin
                  w_fault_evt = 1'b1;
               end else begin
                  w_accept    = 1'b1;
                  w_state_nxt = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (i_flush) begin
               w_state_nxt = S_IDLE;
            end else if (r_lat_cnt == 2'd1) begin
               w_state_nxt = S_CAPT;
            end
         end
         S_CAPT: begin
            w_state_nxt = S_IDLE;
            w_capture   = !i_flush;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc          <= RESET_PC;
         r_lat_cnt     <= 2'd0;
         r_instr       <= 32'd0;
         r_fetch_pc    <= 32'd0;
         r_instr_valid <= 1'b0;
         r_fault       <= 1'b0;
      end else begin
         r_instr_valid <= w_capture;
         r_fault       <= w_fault_evt;
         if (r_state == S_IDLE) begin
            r_pc <= w_pc_eff;
         end
         if (w_accept) begin
            r_lat_cnt <= c_LAT_INIT;
         end else if (r_state == S_WAIT && r_lat_cnt != 2'd0) begin
            r_lat_cnt <= r_lat_cnt - 2'd1;
         end
         if (w_fault_evt) begin
            r_fetch_pc <= w_pc_eff;
         end
         if (w_capture) begin
            r_instr    <= i_rom_data;
            r_fetch_pc <= r_pc;
         end
      end
   end

   assign o_rom_addr    = r_pc[ADDR_W-1:0];
   assign o_instr       = r_instr;
   assign o_fetch_pc    = r_fetch_pc;
   assign o_instr_valid = r_instr_valid;
   assign o_fault       = r_fault;
   assign o_busy        = (r_state == S_WAIT) || (r_state == S_CAPT);
   assign o_pc          = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_ctrl                                           |
// | Brief    : Directed bench with a ROM model and a cycle-level reference.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_ctrl;

   localparam int ADDR_W    = 14;
   localparam int ROM_LAT   = 1;
   localparam int ROM_WORDS = 321;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              fetch_req = 1'b0;
   logic              pc_inc = 1'b0;
   logic              pc_load = 1'b0;
   logic [31:0]       pc_next = 32'd0;
   logic              flush = 1'b0;
   logic [ADDR_W-1:0] rom_addr;
   logic [31:0]       rom_data;
   logic [31:0]       instr;
   logic [31:0]       fetch_pc;
   logic              instr_valid;
   logic              fault;
   logic              busy;
   logic [31:0]       pc;

   int vectors = 0;
   int miscompares = 0;

   logic [31:0] rom [ROM_WORDS];
   logic [31:0] rom_pipe [ROM_LAT];

   instr_fetch_ctrl #(
      .ADDR_W(ADDR_W), .RESET_PC(32'h0), .ROM_LATENCY(ROM_LAT)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .i_fetch_req(fetch_req), .i_pc_inc(pc_inc), .i_pc_load(pc_load),
      .i_pc_next(pc_next), .i_flush(flush),
      .o_rom_addr(rom_addr), .i_rom_data(rom_data),
      .o_instr(instr), .o_fetch_pc(fetch_pc), .o_instr_valid(instr_valid),
      .o_fault(fault), .o_busy(busy), .o_pc(pc)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_rd(input logic [ADDR_W-1:0] a);
      int idx;
      idx = int'(a[ADDR_W-1:2]);
      return (idx < ROM_WORDS) ? rom[idx] : 32'd0;
   endfunction

   // Registered ROM read port with ROM_LAT edges of latency
   always @(posedge clk) begin
      rom_pipe[0] <= rom_rd(rom_addr);
      for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
   end
   assign rom_data = rom_pipe[ROM_LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a fetch accepted at edge n completes at edge n+ROM_LAT+1
   logic [31:0] m_pc = 32'd0, m_instr = 32'd0, m_fpc = 32'd0, m_ppc = 32'd0;
   logic        m_valid = 1'b0, m_fault = 1'b0, m_pend = 1'b0;
   int          m_cyc = 0, m_done = 0;

   initial begin
      logic [31:0] eff;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_pc = 32'd0; m_instr = 32'd0; m_fpc = 32'd0;
            m_valid = 1'b0; m_fault = 1'b0; m_pend = 1'b0;
         end else begin
            m_cyc++;
            m_valid = 1'b0;
            m_fault = 1'b0;
            if (m_pend) begin
               if (flush) begin
                  m_pend = 1'b0;
               end else if (m_cyc == m_done) begin
                  m_instr = rom_rd(m_ppc[ADDR_W-1:0]);
                  m_fpc   = m_ppc;
                  m_valid = 1'b1;
                  m_pend  = 1'b0;
               end
            end else begin
               eff  = pc_load ? pc_next : (pc_inc ? m_pc + 32'd4 : m_pc);
               m_pc = eff;
               if (fetch_req && !flush) begin
                  if (eff[1:0] != 2'b00) begin
                     m_fault = 1'b1;
                     m_fpc   = eff;
                  end else begin
                     m_pend = 1'b1;
                     m_ppc  = eff;
                     m_done = m_cyc + ROM_LAT + 1;
                  end
               end
            end
         end
         #1;
         chk("model", {instr_valid, fault, busy, 29'd0}, {m_valid, m_fault, m_pend, 29'd0});
         chk("model_pc", pc, m_pc);
         chk("model_rom_addr", 32'(rom_addr), 32'(m_pc[ADDR_W-1:0]));
         chk("model_instr", instr, m_instr);
         chk("model_fetch_pc", fetch_pc, m_fpc);
      end
   end

   task automatic set_in(input logic req, input logic inc, input logic load,
                         input logic [31:0] nxt, input logic fl);
      fetch_req = req; pc_inc = inc; pc_load = load; pc_next = nxt; flush = fl;
   endtask

   // Called at a negedge; returns at the negedge where a pulse is visible
   task automatic do_fetch(input logic load, input logic inc, input logic [31:0] nxt);
      int n;
      set_in(1'b1, inc, load, nxt, 1'b0);
      @(negedge clk);
      set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      n = 0;
      while (!(instr_valid || fault) && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (n >= 10) chk("fetch_timeout", 32'(n), 32'd0);
   endtask

   initial begin
      logic [31:0] seq [5];
      seq[0] = 32'h00100093; seq[1] = 32'h00100113; seq[2] = 32'h00208f33;
      seq[3] = 32'h00200e93; seq[4] = 32'h00300193;
      for (int i = 0; i < ROM_WORDS; i++) rom[i] = 32'h13 | (32'(i) << 7);
      rom[0] = 32'h00000093;  rom[5] = 32'h4ddf1663;
      for (int i = 0; i < 5; i++) rom[6+i] = seq[i];
      rom[316] = 32'hc0001073;

      repeat (3) @(negedge clk);
      chk("rst_pc", pc, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_rom_addr", 32'(rom_addr), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      do_fetch(1'b0, 1'b0, 32'd0);
      chk("f0_valid", 32'(instr_valid), 32'd1);
      chk("f0_instr", instr, 32'h00000093);
      chk("f0_fpc", fetch_pc, 32'd0);

      do_fetch(1'b1, 1'b0, 32'h14);
      chk("ld_instr", instr, 32'h4ddf1663);
      chk("ld_fpc", fetch_pc, 32'h14);
      chk("ld_pc", pc, 32'h14);

      for (int i = 0; i < 5; i++) begin
         do_fetch(1'b0, 1'b1, 32'd0);
         chk("seq_valid", 32'(instr_valid), 32'd1);
         chk("seq_instr", instr, seq[i]);
         chk("seq_fpc", fetch_pc, 32'h18 + 32'(4*i));
      end
      chk("seq_pc_end", pc, 32'h28);

      do_fetch(1'b1, 1'b0, 32'h6);
      chk("mis_fault", 32'(fault), 32'd1);
      chk("mis_valid", 32'(instr_valid), 32'd0);
      chk("mis_fpc", fetch_pc, 32'h6);
      chk("mis_instr", instr, 32'h00300193);

      set_in(1'b1, 1'b0, 1'b1, 32'h4f0, 1'b0);
      @(negedge clk);
      set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
      chk("fl_busy_wait", 32'(busy), 32'd1);
      @(negedge clk);
      set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("fl_busy", 32'(busy), 32'd0);
      chk("fl_instr", instr, 32'h00300193);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("fl_no_valid", 32'(instr_valid), 32'd0);
      end
      do_fetch(1'b0, 1'b0, 32'd0);
      chk("refetch_instr", instr, 32'hc0001073);
      chk("refetch_fpc", fetch_pc, 32'h4f0);

      do_fetch(1'b1, 1'b0, 32'h504);
      chk("oor_valid", 32'(instr_valid), 32'd1);
      chk("oor_instr", instr, 32'h0);
      chk("oor_fpc", fetch_pc, 32'h504);

      set_in(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
      @(negedge clk);
      set_in(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("rw_busy", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_pc", pc, 32'd0);
      chk("ar_busy", 32'(busy), 32'd0);
      chk("ar_instr", instr, 32'd0);
      chk("ar_fpc", fetch_pc, 32'd0);
      chk("ar_rom_addr", 32'(rom_addr), 32'd0);
      chk("ar_pulses", {30'd0, instr_valid, fault}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("ar_no_pulse", {30'd0, instr_valid, fault}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
